// File: rtl/hp_hud_ctrl_if.sv
// Pixel/frame stream into the HP HUD controller and the sprite-lookup outputs it returns.
// master drives coordinates, frame pulses and HP; slave is the controller.
interface hp_hud_ctrl_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       frame_start;
   logic [3:0] hp_in;
   logic [7:0] rom_address;
   logic       hud_on;
   logic       pip_empty;
   logic       busy;

   modport master (
      output DrawX, DrawY, frame_start, hp_in,
      input  rom_address, hud_on, pip_empty, busy
   );

   modport slave (
      input  DrawX, DrawY, frame_start, hp_in,
      output rom_address, hud_on, pip_empty, busy
   );
endinterface

// File: rtl/hp_hud_ctrl.sv
// HP pip HUD: animates HP loss (blink) and refill, and maps pixels onto the shared pip sprite ROM.
// Optional blink-on-loss animation is enabled by defining HP_HUD_BLINK_EN.
//
//   state      | meaning
//   IDLE       | hp_disp matches the game HP, no animation
//   GAIN_FILL  | hp_disp climbing one pip per FILL_FRAMES frames toward target
//   LOSS_BLINK | lost pips [lost_lo, lost_hi) blinking for 16 frames (HP_HUD_BLINK_EN only)
module hp_hud_ctrl #(
   parameter logic [9:0] HUD_X0      = 10'd16,
   parameter logic [9:0] HUD_Y0      = 10'd16,
   parameter logic [9:0] PIP_PITCH   = 10'd14,
   parameter logic [3:0] MAX_HP      = 4'd8,
   parameter logic [3:0] FILL_FRAMES = 4'd4
) (
   input logic            vga_clk,
   input logic            reset_n,
   hp_hud_ctrl_if.slave   hif
);

`ifdef HP_HUD_BLINK_EN
   typedef enum logic [1:0] {IDLE, GAIN_FILL, LOSS_BLINK} state_t;
`else
   typedef enum logic [1:0] {IDLE, GAIN_FILL} state_t;
`endif

   state_t     state;
   logic [3:0] hp_disp;
   logic [3:0] target;
   logic [3:0] fill_cnt;
   logic       busy;
`ifdef HP_HUD_BLINK_EN
   logic [3:0] blink_cnt;
   logic [3:0] lost_lo;
   logic [3:0] lost_hi;
`endif

   logic [3:0] hp_smp;
   logic [3:0] tgt_nxt;

   assign hp_smp  = (hif.hp_in > MAX_HP) ? MAX_HP : hif.hp_in;
   assign tgt_nxt = (hp_smp > target) ? hp_smp : target;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         hp_disp   <= MAX_HP;
         target    <= MAX_HP;
         fill_cnt  <= 4'd0;
         busy      <= 1'b0;
`ifdef HP_HUD_BLINK_EN
         blink_cnt <= 4'd0;
         lost_lo   <= 4'd0;
         lost_hi   <= 4'd0;
`endif
      end else if (hif.frame_start) begin
         if (hp_smp < hp_disp) begin
            // A loss preempts whatever animation is running.
            hp_disp <= hp_smp;
            target  <= hp_smp;
`ifdef HP_HUD_BLINK_EN
            state     <= LOSS_BLINK;
            busy      <= 1'b1;
            lost_lo   <= hp_smp;
            lost_hi   <= hp_disp;
            blink_cnt <= 4'd15;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (hp_smp > hp_disp) begin
                     state    <= GAIN_FILL;
                     busy     <= 1'b1;
                     target   <= hp_smp;
                     fill_cnt <= FILL_FRAMES - 4'd1;
                  end
               end
               GAIN_FILL: begin
                  target <= tgt_nxt;
                  if (fill_cnt == 4'd0) begin
                     hp_disp  <= hp_disp + 4'd1;
                     fill_cnt <= FILL_FRAMES - 4'd1;
                     if (hp_disp + 4'd1 >= tgt_nxt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     fill_cnt <= fill_cnt - 4'd1;
                  end
               end
`ifdef HP_HUD_BLINK_EN
               LOSS_BLINK: begin
                  if (blink_cnt == 4'd0) begin
                     if (hp_smp > hp_disp) begin
                        state    <= GAIN_FILL;
                        busy     <= 1'b1;
                        target   <= hp_smp;
                        fill_cnt <= FILL_FRAMES - 4'd1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     blink_cnt <= blink_cnt - 4'd1;
                  end
               end
`endif
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Pip lookup by per-pip range compare; pip lefts are constants so no divider is needed.
   logic       pip_hit;
   logic [3:0] pip_idx;
   logic [3:0] off_x;
   logic [9:0] left;
   logic       y_in;
   logic [3:0] off_y;

   always_comb begin
      pip_hit = 1'b0;
      pip_idx = 4'd0;
      off_x   = 4'd0;
      left    = 10'd0;
      for (int i = 0; i < 9; i++) begin
         left = HUD_X0 + 10'(i) * PIP_PITCH;
         if (!pip_hit && (4'(i) < MAX_HP) && (hif.DrawX >= left) && (hif.DrawX < left + 10'd12)) begin
            pip_hit = 1'b1;
            pip_idx = 4'(i);
            off_x   = 4'(hif.DrawX - left);
         end
      end
   end

   assign y_in  = (hif.DrawY >= HUD_Y0) && (hif.DrawY < HUD_Y0 + 10'd16);
   assign off_y = 4'(hif.DrawY - HUD_Y0);

   logic       hud_on_d;
   logic       empty_d;
   logic [7:0] rom_d;
   logic       in_lost;

   always_comb begin
      in_lost  = 1'b0;
`ifdef HP_HUD_BLINK_EN
      in_lost  = (state == LOSS_BLINK) && (pip_idx >= lost_lo) && (pip_idx < lost_hi);
      hud_on_d = pip_hit && y_in && !(in_lost && !blink_cnt[2]);
`else
      hud_on_d = pip_hit && y_in;
`endif
      empty_d  = hud_on_d && !in_lost && (pip_idx >= hp_disp);
      rom_d    = hud_on_d ? (8'(off_y) * 8'd12 + 8'(off_x)) : 8'd0;
   end

   logic [7:0] rom_q;
   logic       hud_on_q;
   logic       empty_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_q    <= 8'd0;
         hud_on_q <= 1'b0;
         empty_q  <= 1'b0;
      end else begin
         rom_q    <= rom_d;
         hud_on_q <= hud_on_d;
         empty_q  <= empty_d;
      end
   end

   assign hif.rom_address = rom_q;
   assign hif.hud_on      = hud_on_q;
   assign hif.pip_empty   = empty_q;
   assign hif.busy        = busy;

endmodule

// File: tb/tb_hp_hud_ctrl.sv
// Self-checking bench for hp_hud_ctrl: directed scenarios plus random HP/pixel traffic
// checked against a frame-level behavioural model of the HUD.
module tb_hp_hud_ctrl;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   hp_hud_ctrl_if hif ();

   hp_hud_ctrl dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .hif     (hif)
   );

   always #5 vga_clk = ~vga_clk;

`ifdef HP_HUD_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   localparam int MAXHP = 8;
   localparam int FF    = 4;

   int n_cmp = 0;
   int n_err = 0;

   // model: mode 0 idle, 1 refilling, 2 blinking; m_n counts frames since entering the mode
   int m_hp, m_tgt, m_mode, m_n, m_base, m_lo, m_hi;

   task automatic model_reset();
      m_hp = MAXHP; m_tgt = MAXHP; m_mode = 0; m_n = 0; m_base = MAXHP; m_lo = 0; m_hi = 0;
   endtask

   task automatic start_gain(input int s);
      m_mode = 1; m_n = 0; m_base = m_hp; m_tgt = s;
   endtask

   task automatic model_frame(input int raw);
      int s;
      s = (raw > MAXHP) ? MAXHP : raw;
      if (s < m_hp) begin
         if (BLINK) begin
            m_mode = 2; m_n = 0; m_lo = s; m_hi = m_hp;
         end else begin
            m_mode = 0;
         end
         m_hp = s;
      end else if (m_mode == 0) begin
         if (s > m_hp) start_gain(s);
      end else if (m_mode == 1) begin
         if (s > m_tgt) m_tgt = s;
         m_n++;
         m_hp = m_base + m_n / FF;
         if (m_hp >= m_tgt) m_mode = 0;
      end else begin
         m_n++;
         if (m_n == 16) begin
            if (s > m_hp) start_gain(s);
            else m_mode = 0;
         end
      end
   endtask

   // {hud_on, pip_empty, rom_address} expected for a pixel under the current model state
   function automatic logic [9:0] exp_pix(input int x, input int y);
      logic h, e;
      logic [7:0] r;
      int idx, off;
      h = 0; e = 0; r = 0;
      if (y >= 16 && y < 32 && x >= 16) begin
         idx = (x - 16) / 14;
         off = (x - 16) % 14;
         if (idx < MAXHP && off < 12) begin
            h = 1;
            e = (idx >= m_hp);
            r = 8'((y - 16) * 12 + off);
            if (m_mode == 2 && idx >= m_lo && idx < m_hi) begin
               e = 0;
               if ((((15 - m_n) >> 2) & 1) == 0) begin
                  h = 0; r = 0;
               end
            end
         end
      end
      return {h, e, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pix(input int x, input int y, input string tag);
      logic [9:0] e;
      hif.DrawX = 10'(x);
      hif.DrawY = 10'(y);
      @(posedge vga_clk); #1;
      e = exp_pix(x, y);
      check({tag, "_hud"},   32'(hif.hud_on),      32'(e[9]));
      check({tag, "_empty"}, 32'(hif.pip_empty),   32'(e[8]));
      check({tag, "_rom"},   32'(hif.rom_address), 32'(e[7:0]));
   endtask

   task automatic frame(input int h);
      hif.hp_in       = 4'(h);
      hif.frame_start = 1'b1;
      @(posedge vga_clk); #1;
      hif.frame_start = 1'b0;
      model_frame(h);
      check("busy", 32'(hif.busy), 32'(m_mode != 0));
   endtask

   task automatic settle(input int h);
      for (int k = 0; k < 40 && m_mode != 0; k++) frame(h);
      check("settled", 32'(hif.busy), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_hud"},   32'(hif.hud_on),      32'd0);
      check({tag, "_empty"}, 32'(hif.pip_empty),   32'd0);
      check({tag, "_rom"},   32'(hif.rom_address), 32'd0);
      check({tag, "_busy"},  32'(hif.busy),        32'd0);
   endtask

   initial begin
      hif.DrawX = 10'd16; hif.DrawY = 10'd16; hif.frame_start = 1'b0; hif.hp_in = 4'd8;
      model_reset();
      #3;
      check_reset_outs("in_reset");
      #14 reset_n = 1'b1;
      @(posedge vga_clk); #1;

      // pixel mapping with full HP
      pix(16, 16, "pip0_origin");
      pix(63, 20, "pip3_off53");
      pix(28, 20, "gap");
      pix(27, 31, "pip0_last");
      pix(16, 32, "below");
      pix(15, 20, "left_edge");
      pix(125, 16, "pip7_last_x");
      pix(128, 16, "past_pip7");

      // clamped over-range HP
      frame(12);
      pix(114, 20, "clamp_pip7");

      // loss 8 -> 5 and its whole animation
      frame(5);
      for (int k = 0; k < 18; k++) begin
         pix(16 + 6 * 14 + 2, 18, "loss_pip6");
         pix(16 + 4 * 14 + 2, 18, "loss_pip4");
         frame(5);
      end
      pix(16 + 6 * 14 + 2, 18, "after_loss_pip6");

      // refill 2 -> 5
      frame(2);
      settle(2);
      frame(5);
      for (int k = 0; k < 13; k++) begin
         pix(16 + 2 * 14, 25, "gain_pip2");
         pix(16 + 4 * 14, 25, "gain_pip4");
         frame(5);
      end

      // loss during refill
      frame(2);
      settle(2);
      frame(5);
      for (int k = 0; k < 8; k++) frame(5);
      frame(3);
      pix(16 + 3 * 14 + 1, 17, "loss_in_gain_pip3");
      frame(3);
      pix(16 + 3 * 14 + 1, 17, "loss_in_gain_pip3b");
      settle(3);

      // random HP traffic with glitches between frame pulses
      begin
         int cur;
         cur = 3;
         for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 15);
            for (int p = 0; p < 2; p++) begin
               hif.hp_in = 4'($urandom_range(0, 15));
               pix($urandom_range(0, 140), $urandom_range(10, 35), "rnd_pix");
            end
            frame(cur);
         end
      end

      // async reset in the middle of an animation
      frame(2);
      settle(2);
      frame(7);
      hif.DrawX = 10'd16; hif.DrawY = 10'd16;
      @(posedge vga_clk); #2;
      reset_n = 1'b0;
      #1;
      check_reset_outs("mid_reset");
      model_reset();
      #4 reset_n = 1'b1;
      @(posedge vga_clk); #1;
      pix(16 + 7 * 14, 16, "post_reset_pip7");
      frame(6);
      pix(16 + 7 * 14, 16, "post_reset_loss_pip7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
